// File: rtl/xor_parity_rx_pkg.sv
// ---------------------------------------------------------------------------
// xor_parity_rx_pkg
// Shared definitions for the XOR even/odd parity serial link.
// The receiver uses them now, and the matching transmitter can reuse them.
//   - FSM state encoding: raw localparams plus an enum built on them.
//   - Frame constants: start bit and stop bit levels.
//   - cnt_width(): width of the data-bit counter for a given frame width.
// ---------------------------------------------------------------------------
package xor_parity_rx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE   = ST_IDLE,
    RX_DATA   = ST_DATA,
    RX_PARITY = ST_PARITY,
    RX_STOP   = ST_STOP
  } rx_state_t;

  // ceil(log2(width)), never less than one bit, so that a counter
  // can always be declared.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/xor_parity_rx_acc.sv
// ---------------------------------------------------------------------------
// xor_par_acc
// Single-bit running XOR accumulator: one flop and one XOR gate.
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset (clears q)
//   clr     load clr_val into q (has priority over en)
//   clr_val seed value; gives the parity sense
//   en      fold d into q this cycle
//   d       bit to fold in
//   q       accumulated parity
// ---------------------------------------------------------------------------
module xor_par_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic clr_val,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= 1'b0;
    end else if (clr) begin
      q_reg <= clr_val;
    end else if (en) begin
      q_reg <= q_reg ^ d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/xor_parity_rx.sv
// ---------------------------------------------------------------------------
// xor_parity_rx
// Serial frame receiver with a parity checker.
// Frame format: start(0), WIDTH data bits (LSB first), parity, stop(1).
// A bit is taken only on cycles where en=1.
// Parameters:
//   WIDTH  data bits per frame (2..16)
//   ODD    0 = even parity, 1 = odd parity
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   en     bit strobe
//   sin    serial line; idles high
//   dout   last received word; held until the next frame completes
//   valid  one-cycle pulse when a frame completes
//   perr   parity error of the last frame; held
//   ferr   framing error (stop bit was 0) of the last frame; held
//   busy   high while the FSM is outside IDLE; driven from a register
// ---------------------------------------------------------------------------
module xor_parity_rx
  import xor_parity_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             perr,
  output logic             ferr,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  rx_state_t        state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_shift;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             valid_reg;
  logic             perr_reg;
  logic             ferr_reg;
  logic             busy_reg;

  logic             acc_clr;
  logic             acc_en;
  logic             acc_q;

  // Right shift with the new bit entering at the MSB. After WIDTH shifts,
  // the first data bit (the LSB) ends up in bit 0.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign sreg_shift[gi] = sreg_reg[gi + 1];
    end
  endgenerate
  assign sreg_shift[WIDTH-1] = sin;

  // The accumulator is seeded with ODD when the start bit is taken.
  // After the data bits and the parity bit are folded in, zero means the
  // parity is correct for either parity sense.
  xor_par_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .clr_val (ODD),
    .en      (acc_en),
    .d       (sin),
    .q       (acc_q)
  );

  always_comb begin
    state_next = state_reg;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    if (en) begin
      case (state_reg)
        RX_IDLE: begin
          if (sin == START_BIT) begin
            state_next = RX_DATA;
            acc_clr    = 1'b1;
          end
        end
        RX_DATA: begin
          acc_en = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = RX_PARITY;
          end
        end
        RX_PARITY: begin
          acc_en     = 1'b1;
          state_next = RX_STOP;
        end
        RX_STOP: begin
          // A low stop bit is only reported as an error. It is never
          // taken as the start of a new frame.
          state_next = RX_IDLE;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RX_IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != RX_IDLE);
      valid_reg <= 1'b0;
      if (en) begin
        case (state_reg)
          RX_IDLE: begin
            if (sin == START_BIT) begin
              cnt_reg <= '0;
            end
          end
          RX_DATA: begin
            sreg_reg <= sreg_shift;
            // The counter stops at the last index, so it never wraps
            // inside a frame, even when WIDTH is a power of two.
            if (cnt_reg != CNT_LAST) begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          RX_STOP: begin
            dout_reg  <= sreg_reg;
            perr_reg  <= acc_q;
            ferr_reg  <= (sin != STOP_BIT);
            valid_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign perr  = perr_reg;
  assign ferr  = ferr_reg;
  assign busy  = busy_reg;

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
- Serial frame receiver and parity checker. It is the receiving end of the team's XOR-based even/odd parity serial link.
- Accepts one bit per qualified clock (EN strobe) in the frame format: start bit (0), WIDTH data bits LSB first, parity bit, stop bit (1).
- Rebuilds the data word and checks parity with a running XOR accumulator.
- Flags parity and framing errors, then presents the word with a one-cycle VALID pulse.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..16).
- ODD, 0, parity sense: 0 = even parity (data plus parity bit has an even count of ones), 1 = odd parity.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  synchronous reset, active-low, sampled on the rising edge of CLK.
- EN  input  1  bit strobe; SIN is sampled only on cycles where EN=1.
- SIN  input  1  serial line; idles at 1.
- DOUT  output  WIDTH  last received data word; holds until the next completed frame.
- VALID  output  1  one-cycle pulse when a frame completes.
- PERR  output  1  parity error of the last frame; valid with VALID, held afterwards.
- FERR  output  1  framing error (stop bit = 0) of the last frame; valid with VALID, held afterwards.
- BUSY  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - State goes to IDLE.
  - DOUT=0, VALID=0, PERR=0, FERR=0, BUSY=0.
  - Shift register, bit counter and parity accumulator are cleared.
- Reset takes priority over EN. A reset mid-frame abandons the frame and no VALID is produced.
- States: IDLE, DATA, PARITY, STOP. On cycles with EN=0, state and all registers hold, except that VALID returns to 0.
- IDLE:
  - EN=1 and SIN=0: go to DATA, set cnt=0, set acc=ODD.
  - EN=1 and SIN=1: stay in IDLE.
- DATA, on EN=1:
  - Shift SIN into sreg at the MSB and shift right, so the first data bit ends up in bit 0.
  - acc <= acc XOR SIN; cnt <= cnt+1.
  - When cnt==WIDTH-1 (this is the last data bit), go to PARITY.
  - cnt is ceil(log2(WIDTH)) bits wide and does not wrap within a frame.
- PARITY, on EN=1:
  - acc <= acc XOR SIN; go to STOP.
  - After this update, acc=0 means the parity is correct for either value of ODD.
- STOP, on EN=1:
  - Next cycle: DOUT <= sreg, PERR <= acc, FERR <= ~SIN, VALID <= 1.
  - Go to IDLE.
- A frame that has FERR=1 still updates DOUT and still pulses VALID. The error flags are informational and never suppress the frame.
- Latency: VALID is high in the cycle after the CLK edge where EN=1 sampled the stop bit.
- Back-to-back frames:
  - A start bit may be sampled on the very next EN after the stop bit.
  - VALID for the previous frame and the acceptance of the new start bit can occur in the same cycle without interfering.
- A 0 in the stop position is not treated as a start bit. The receiver returns to IDLE and needs a fresh EN with SIN=0 to start a frame.
- BUSY is registered from state: it is 1 in the cycle after the start bit is accepted and 0 in the cycle VALID is high.

Decomposition:
- Shared package/include file:
  - State encoding localparams ST_IDLE=2'd0, ST_DATA=2'd1, ST_PARITY=2'd2, ST_STOP=2'd3.
  - Frame constants START_BIT=1'b0, STOP_BIT=1'b1.
  - The counter-width function.
  - The transmitter block will reuse these.
- One sub-module is natural: xor_par_acc.
  - Contents: a single-bit running XOR accumulator (a flop plus an XOR gate) with ports CLK, RST_N, CLR, CLR_VAL, EN, D, Q.
  - It is instantiated once. The top holds the FSM, shift register, counter and output registers.

Test Plan:
- Reset check: hold RST_N=0 for 3 cycles, with EN=1 and SIN toggling -> DOUT=0, VALID=0, PERR=0, FERR=0, BUSY=0 throughout.
- Good frame, even parity (ODD=0, WIDTH=8): send data 0xA5 as bits 0,1,0,1,0,0,1,0,1,0,1 (start, eight data bits, parity, stop), with EN=1 every cycle -> VALID pulses once, DOUT=8'hA5, PERR=0, FERR=0.
- Parity error: same frame as above but with the parity bit = 1 -> DOUT=8'hA5, PERR=1, FERR=0, VALID pulses once.
- Framing error plus EN gaps:
  - Send data 0x3C with correct parity 0 and stop bit = 0, with EN high only every third cycle.
  - Required: DOUT=8'h3C, FERR=1, PERR=0.
  - Required: VALID appears exactly 1 cycle after the EN that sampled the stop bit.
  - Required: the next frame is not started until a later EN sees SIN=0.
- Reset mid-frame: assert RST_N=0 after the 4th data bit -> no VALID, all outputs 0. A following full frame of 0xFF (parity bit 0) gives DOUT=8'hFF, PERR=0.
- Back-to-back frames with ODD=1: send 0x01 (parity bit 0), then 0x00 (parity bit 1) with no idle bits between them -> two VALID pulses, DOUT=8'h01 then 8'h00, PERR=0 both times, BUSY low only in the VALID cycles.
